// File: rtl/flag_pkg.sv
// Shared definitions for the NZCV flag producer and the condition-check logic.
package flag_pkg;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned OPC_W   = 2;

  // Operation class encodings
  localparam logic [OPC_W-1:0] OP_ARITH = 2'b00;
  localparam logic [OPC_W-1:0] OP_LOGIC = 2'b01;
  localparam logic [OPC_W-1:0] OP_MUL   = 2'b10;
  localparam logic [OPC_W-1:0] OP_CMP   = 2'b11;

  // Bit positions inside the packed {C,N,V,Z} word
  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  // Condition codes evaluated by the condition-check block
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  // Packed flag word, field order matches FLAG_* indices
  typedef struct packed {
    logic c;
    logic n;
    logic v;
    logic z;
  } flags_t;

  // Shadow-copy state
  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SAVED  = 1'b1
  } state_t;

  // Assemble a flag word from individual bits
  function automatic flags_t pack_flags(input logic c, input logic n,
                                        input logic v, input logic z);
    flags_t f;
    f.c = c;
    f.n = n;
    f.v = v;
    f.z = z;
    return f;
  endfunction

endpackage

// File: rtl/flag_compute.sv
// Combinational NZCV derivation from an ALU/shifter result.
module flag_compute
  import flag_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] result,
  input  logic              alu_carry,
  input  logic              alu_overflow,
  input  logic              shifter_carry,
  input  logic [OPC_W-1:0]  op_class,
  input  logic              prev_c,
  input  logic              prev_v,
  output flags_t            flags_c
);

  // N/Z always from the result; C/V source depends on the operation class
  always_comb begin
    flags_c.n = result[DATA_W-1];
    flags_c.z = (result == '0);
    flags_c.c = prev_c;
    flags_c.v = prev_v;
    case (op_class)
      OP_ARITH, OP_CMP: begin
        flags_c.c = alu_carry;
        flags_c.v = alu_overflow;
      end
      OP_LOGIC: flags_c.c = shifter_carry;
      default: ;
    endcase
  end

endmodule

// File: rtl/flag_register_unit.sv
// Architectural NZCV flag register with MSR writes and a one-deep exception
// shadow copy. Optional macro FLAG_FORWARD_EN adds a combinational FlagsNext
// output exposing the value Flags will take at the next edge.
module flag_register_unit
  import flag_pkg::*;
#(
  parameter int unsigned        DATA_W      = 32,
  parameter logic [FLAGS_W-1:0] RESET_FLAGS = 4'b0000
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               AluValid,
  input  logic [DATA_W-1:0]  AluResult,
  input  logic               AluCarry,
  input  logic               AluOverflow,
  input  logic               ShifterCarry,
  input  logic [OPC_W-1:0]   OpClass,
  input  logic               SetFlags,
  input  logic               CondPass,
  input  logic               MsrWrite,
  input  logic [FLAGS_W-1:0] MsrData,
  input  logic               ExcEntry,
  input  logic               ExcReturn,
  output logic [FLAGS_W-1:0] Flags,
  output logic               SavedValid,
`ifdef FLAG_FORWARD_EN
  output logic               UpdateErr,
  output logic [FLAGS_W-1:0] FlagsNext
`else
  output logic               UpdateErr
`endif
);

  state_t               state_q, state_d;
  logic [FLAGS_W-1:0]   saved_q, saved_d;
  logic [FLAGS_W-1:0]   flags_d;
  logic                 err_d;
  logic                 alu_update;
  flags_t               alu_flags;

  flag_compute #(.DATA_W(DATA_W)) u_compute (
    .result        (AluResult),
    .alu_carry     (AluCarry),
    .alu_overflow  (AluOverflow),
    .shifter_carry (ShifterCarry),
    .op_class      (OpClass),
    .prev_c        (Flags[FLAG_C]),
    .prev_v        (Flags[FLAG_V]),
    .flags_c       (alu_flags)
  );

  assign alu_update = AluValid & SetFlags & CondPass;

  // Next-state and update priority: return > MSR > ALU; entry saves pre-edge flags
  always_comb begin
    state_d = state_q;
    flags_d = Flags;
    saved_d = saved_q;
    err_d   = UpdateErr;
    if (ExcReturn) begin
      if (state_q == ST_SAVED) begin
        flags_d = saved_q;
        state_d = ST_NORMAL;
      end else begin
        err_d = 1'b1;
      end
    end else if (MsrWrite) begin
      flags_d = MsrData;
    end else if (alu_update) begin
      flags_d = alu_flags;
    end
    if (ExcEntry) begin
      saved_d = Flags;
      state_d = ST_SAVED;
    end
  end

  // State, flag, shadow and sticky-error registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_NORMAL;
      Flags     <= RESET_FLAGS;
      saved_q   <= RESET_FLAGS;
      UpdateErr <= 1'b0;
    end else begin
      state_q   <= state_d;
      Flags     <= flags_d;
      saved_q   <= saved_d;
      UpdateErr <= err_d;
    end
  end

  assign SavedValid = (state_q == ST_SAVED);

`ifdef FLAG_FORWARD_EN
  assign FlagsNext = flags_d;
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
// Directed self-checking bench for flag_register_unit.
module tb_flag_register_unit;

  localparam int unsigned DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              AluValid;
  logic [DATA_W-1:0] AluResult;
  logic              AluCarry;
  logic              AluOverflow;
  logic              ShifterCarry;
  logic [1:0]        OpClass;
  logic              SetFlags;
  logic              CondPass;
  logic              MsrWrite;
  logic [3:0]        MsrData;
  logic              ExcEntry;
  logic              ExcReturn;
  logic [3:0]        Flags;
  logic              SavedValid;
  logic              UpdateErr;
`ifdef FLAG_FORWARD_EN
  logic [3:0]        FlagsNext;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  flag_register_unit #(.DATA_W(DATA_W), .RESET_FLAGS(4'b0000)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .AluValid     (AluValid),
    .AluResult    (AluResult),
    .AluCarry     (AluCarry),
    .AluOverflow  (AluOverflow),
    .ShifterCarry (ShifterCarry),
    .OpClass      (OpClass),
    .SetFlags     (SetFlags),
    .CondPass     (CondPass),
    .MsrWrite     (MsrWrite),
    .MsrData      (MsrData),
    .ExcEntry     (ExcEntry),
    .ExcReturn    (ExcReturn),
    .Flags        (Flags),
    .SavedValid   (SavedValid),
`ifdef FLAG_FORWARD_EN
    .UpdateErr    (UpdateErr),
    .FlagsNext    (FlagsNext)
`else
    .UpdateErr    (UpdateErr)
`endif
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic idle();
    AluValid     = 1'b0;
    AluResult    = '0;
    AluCarry     = 1'b0;
    AluOverflow  = 1'b0;
    ShifterCarry = 1'b0;
    OpClass      = 2'b00;
    SetFlags     = 1'b0;
    CondPass     = 1'b0;
    MsrWrite     = 1'b0;
    MsrData      = 4'b0000;
    ExcEntry     = 1'b0;
    ExcReturn    = 1'b0;
  endtask

  // Apply current inputs across one rising edge, sample 1 time unit later, then idle
  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic alu(input logic [1:0] opc, input logic [DATA_W-1:0] res,
                     input logic c, input logic v, input logic sc,
                     input logic s, input logic cp);
    AluValid     = 1'b1;
    OpClass      = opc;
    AluResult    = res;
    AluCarry     = c;
    AluOverflow  = v;
    ShifterCarry = sc;
    SetFlags     = s;
    CondPass     = cp;
  endtask

  task automatic msr(input logic [3:0] d);
    MsrWrite = 1'b1;
    MsrData  = d;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    #12;
    check("reset_flags", Flags, 4'b0000);
    check("reset_saved_valid", {3'b0, SavedValid}, 4'b0001 & 4'b0000);
    check("reset_err", {3'b0, UpdateErr}, 4'b0000);
    @(negedge Clk);
    Reset = 1'b0;

    // Load 1111 with a pending save, then async reset between edges
    ExcEntry = 1'b1;
    msr(4'b1111);
    tick();
    check("msr_1111", Flags, 4'b1111);
    check("entry_saved_valid", {3'b0, SavedValid}, 4'b0001);
    Reset = 1'b1;
    #2;
    check("async_reset_flags", Flags, 4'b0000);
    check("async_reset_saved_valid", {3'b0, SavedValid}, 4'b0000);
    @(negedge Clk);
    Reset = 1'b0;

    // Arith zero with carry
    alu(2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("arith_zero_carry", Flags, 4'b1001);

    // Logic op keeps V
    msr(4'b0010);
    tick();
    check("msr_0010", Flags, 4'b0010);
    alu(2'b01, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("logic_neg_keep_v", Flags, 4'b0110);

    // Missing qualifiers leave flags alone
    for (int i = 0; i < 3; i++) begin
      alu(2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      check("cond_fail_hold", Flags, 4'b0110);
    end
    for (int i = 0; i < 3; i++) begin
      alu(2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      tick();
      check("no_s_hold", Flags, 4'b0110);
    end
    alu(2'b00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    AluValid = 1'b0;
    tick();
    check("no_valid_hold", Flags, 4'b0110);

    // Multiply keeps C,V; compare behaves as arith
    alu(2'b10, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    check("mul_keep_cv", Flags, 4'b0011);
    alu(2'b11, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    check("cmp_as_arith", Flags, 4'b0110);

    // Entry with simultaneous ALU update, then return
    msr(4'b0100);
    tick();
    check("msr_0100", Flags, 4'b0100);
    ExcEntry = 1'b1;
    alu(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("entry_alu_flags", Flags, 4'b0001);
    check("entry_alu_saved_valid", {3'b0, SavedValid}, 4'b0001);
    alu(2'b00, 32'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("in_saved_alu", Flags, 4'b1000);
    ExcReturn = 1'b1;
    tick();
    check("return_restore", Flags, 4'b0100);
    check("return_saved_valid", {3'b0, SavedValid}, 4'b0000);

    // Return with nothing saved -> sticky error
    ExcReturn = 1'b1;
    tick();
    check("bad_return_err", {3'b0, UpdateErr}, 4'b0001);
    check("bad_return_flags", Flags, 4'b0100);
    tick();
    check("err_sticky", {3'b0, UpdateErr}, 4'b0001);

    // MSR beats ALU
    msr(4'b1010);
    alu(2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    check("msr_over_alu", Flags, 4'b1010);

    // Return beats MSR
    ExcEntry = 1'b1;
    tick();
    msr(4'b0000);
    tick();
    check("msr_in_saved", Flags, 4'b0000);
    ExcReturn = 1'b1;
    msr(4'b1111);
    tick();
    check("return_over_msr", Flags, 4'b1010);
    check("return_over_msr_sv", {3'b0, SavedValid}, 4'b0000);

    // Nested entry overwrites the shadow copy
    ExcEntry = 1'b1;
    tick();
    msr(4'b0101);
    tick();
    ExcEntry = 1'b1;
    msr(4'b1100);
    tick();
    check("nested_msr", Flags, 4'b1100);
    check("nested_saved_valid", {3'b0, SavedValid}, 4'b0001);
    ExcReturn = 1'b1;
    tick();
    check("nested_return", Flags, 4'b0101);

    // Entry and return together: restore, then save pre-edge flags
    ExcEntry = 1'b1;
    msr(4'b0011);
    tick();
    check("entry_msr", Flags, 4'b0011);
    ExcEntry  = 1'b1;
    ExcReturn = 1'b1;
    tick();
    check("entry_return_flags", Flags, 4'b0101);
    check("entry_return_sv", {3'b0, SavedValid}, 4'b0001);
    check("entry_return_no_err_change", {3'b0, UpdateErr}, 4'b0001);
    ExcReturn = 1'b1;
    tick();
    check("final_return", Flags, 4'b0011);
    check("final_sv", {3'b0, SavedValid}, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/flag_register_unit.md
Name: flag_register_unit

Overview:
- Producer of the 4-bit NZCV status word that the condition-check logic consumes.
- Computes N, Z, C and V from the ALU/shifter result of each instruction.
- Commits them to an architectural flag register only when the instruction has its S bit set and its condition passed.
- Supports MSR-style direct flag writes and a one-deep saved copy (SPSR shadow) for exception entry and return.

Parameters:
- DATA_W, 32, ALU result width; N is taken from bit DATA_W-1.
- RESET_FLAGS, 4'b0000, value loaded into Flags and SavedFlags on reset.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- AluValid  in  1  an instruction result is present this cycle.
- AluResult  in  DATA_W  ALU result.
- AluCarry  in  1  adder carry-out (carry = NOT borrow for subtract).
- AluOverflow  in  1  adder signed overflow.
- ShifterCarry  in  1  barrel-shifter carry-out.
- OpClass  in  2  00 arith, 01 logic, 10 multiply, 11 compare-only (treated as arith).
- SetFlags  in  1  S bit of the instruction.
- CondPass  in  1  condition-check result for the same instruction.
- MsrWrite  in  1  direct flag write strobe.
- MsrData  in  4  flags to write, packed {C,N,V,Z}.
- ExcEntry  in  1  exception entry: save current flags.
- ExcReturn  in  1  exception return: restore saved flags.
- Flags  out  4  architectural flags, packed {C,N,V,Z}; Flags[3]=C, [2]=N, [1]=V, [0]=Z.
- SavedValid  out  1  shadow copy holds a saved value.
- UpdateErr  out  1  sticky: ExcReturn seen while SavedValid=0.

Behaviour:
- Reset (async, active-high): Flags=RESET_FLAGS, SavedFlags=RESET_FLAGS, SavedValid=0, UpdateErr=0, FSM=NORMAL.
- Latency: every update is registered. Flags change on the rising edge after the qualifying inputs; there is no combinational path from inputs to Flags.
- ALU update fires when AluValid & SetFlags & CondPass. Computed flags:
  - N = AluResult[DATA_W-1].
  - Z = (AluResult == 0).
  - arith/compare: C = AluCarry, V = AluOverflow.
  - logic: C = ShifterCarry, V unchanged.
  - multiply: C and V unchanged.
- Any missing qualifier (AluValid, SetFlags or CondPass low) leaves Flags unchanged.
- FSM states NORMAL and SAVED:
  - NORMAL + ExcEntry -> SAVED: SavedFlags <= Flags (pre-update value), SavedValid=1.
  - SAVED + ExcReturn -> NORMAL: Flags <= SavedFlags, SavedValid=0.
  - SAVED + ExcEntry (nested): SavedFlags overwritten with current Flags; state stays SAVED.
  - NORMAL + ExcReturn: Flags unchanged, UpdateErr set (sticky until Reset).
- Same-cycle priority, highest first: ExcReturn > MsrWrite > ALU update.
  - ExcEntry is independent. It samples Flags before this edge's update, so entry plus an ALU update in one cycle saves the old flags and Flags takes the new value.
  - ExcEntry together with ExcReturn: the return is processed first, then the save captures the pre-edge Flags; resulting state SAVED.
- MsrWrite: Flags <= MsrData; ignores SetFlags and CondPass.
- Reset mid-operation: all state is discarded immediately, including a pending save.

Optional Feature:
- Macro: FLAG_FORWARD_EN.
- When defined: extra output FlagsNext [3:0] drives, combinationally, the value Flags will take at the next edge (same priority logic). This lets condition evaluation of the following instruction bypass the register.
- When undefined: the port is absent and consumers see Flags only, one cycle after update.

Decomposition:
- Shared package flag_pkg holds:
  - OpClass encodings (OP_ARITH, OP_LOGIC, OP_MUL, OP_CMP).
  - Flag bit indices (FLAG_C=3, FLAG_N=2, FLAG_V=1, FLAG_Z=0).
  - FSM state encodings.
  - Condition-code constants, shared with the condition-check block.
- One sub-module, flag_compute: purely combinational N/Z/C/V derivation from the result, carry and OpClass.
- The register, FSM and priority logic stay in the top module.

Test Plan:
- Reset with Flags previously 4'b1111 -> Flags=0000, SavedValid=0 asynchronously, before the next Clk edge.
- Arith, AluResult=0, AluCarry=1, AluOverflow=0, SetFlags=1, CondPass=1 -> next edge Flags=4'b1001 (C=1, Z=1).
- Logic, AluResult=32'h8000_0000, ShifterCarry=0, prior V=1, SetFlags=1 -> Flags=4'b0110 (N=1, V kept).
- Same stimulus with CondPass=0 or SetFlags=0 -> Flags unchanged over 3 cycles.
- Flags=0100, pulse ExcEntry together with arith result 0 (carry 0) -> Flags=0001, SavedValid=1. Later ExcReturn -> Flags=0100, SavedValid=0.
- ExcReturn with SavedValid=0 -> UpdateErr=1 and stays 1. Same-cycle MsrWrite=1010 with a qualifying ALU update -> Flags=1010.
